music_streamer: RTL and testbench
=================================

Name: music_streamer

Overview:
- Sequencer directly upstream of the piezo tone generator.
- Walks a synchronous note ROM, one entry per beat, and presents the current tone period plus an enable that drive the tone generator's period and output_enable inputs.
- Supports play/pause, reverse direction and tempo up/down from single-cycle user pulses; button conditioning happens upstream.
- Runs on the 33 MHz board clock.

Parameters:
- ADDR_W, 10, ROM address width; song length is 2^ADDR_W notes.
- PERIOD_W, 24, tone period width in clock cycles.
- BEAT_W, 24, width of the beat counter and beat length.
- BEAT_INIT, 1320000, clock cycles per note after reset (1/25 s at 33 MHz).
- BEAT_STEP, 66000, change in beat length per tempo pulse.
- BEAT_MIN, 330000, shortest beat length (fastest tempo).
- BEAT_MAX, 3300000, longest beat length (slowest tempo).

Ports:
- clk  in  1  board clock.
- rst  in  1  synchronous, active-high reset.
- play_pause  in  1  one-cycle pulse; toggles PLAYING/PAUSED.
- reverse  in  1  one-cycle pulse; toggles the step direction.
- tempo_up  in  1  one-cycle pulse; shortens the beat.
- tempo_down  in  1  one-cycle pulse; lengthens the beat.
- rom_addr  out  ADDR_W  note ROM address.
- rom_data  in  PERIOD_W  note ROM data, valid 1 cycle after rom_addr.
- tone_period  out  PERIOD_W  registered period to the tone generator.
- tone_enable  out  1  drives the tone generator output_enable.
- status  out  2  bit0 = playing, bit1 = reversed; for LEDs.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = PAUSED, direction = forward, rom_addr = 0
  - beat_len = BEAT_INIT, beat_cnt = 0
  - tone_period = 0, tone_enable = 0, status = 2'b00
- States:
  - PAUSED: play_pause -> PLAYING.
  - PLAYING: play_pause -> PAUSED.
  - No other states.
- Beat counter:
  - Runs only in PLAYING; frozen (not cleared) in PAUSED.
  - Counts 0 .. beat_len-1.
  - Terminal condition is beat_cnt >= beat_len-1. On terminal: beat_cnt <= 0 and the address advances.
- Address advance:
  - Forward: rom_addr+1. Reversed: rom_addr-1.
  - Arithmetic is modulo 2^ADDR_W, so max wraps to 0 and 0 wraps to max.
  - The song loops indefinitely; there is no end-of-song stop.
- Data path:
  - tone_period <= rom_data every cycle.
  - Latency: tone_period reflects a new rom_addr exactly 2 cycles after rom_addr changes (1 cycle ROM read + 1 output register).
- tone_enable:
  - Registered.
  - Equals 1 iff state is PLAYING and rom_data != 0.
  - A period of 0 encodes a rest.
- Tempo:
  - tempo_up: beat_len <= max(beat_len-BEAT_STEP, BEAT_MIN).
  - tempo_down: beat_len <= min(beat_len+BEAT_STEP, BEAT_MAX).
  - Both asserted in the same cycle: no change.
  - Tempo changes are accepted in either state.
  - The new beat_len takes effect from the next cycle. If beat_cnt is already >= new beat_len-1, that next cycle is terminal, so no overshoot.
- Reverse:
  - Toggles direction immediately and is accepted in either state.
  - Does not reset beat_cnt.
  - If reverse coincides with a terminal cycle, the step in that cycle uses the old direction.
- Simultaneous pulses: play_pause together with reverse/tempo pulses all take effect in the same cycle.
- A terminal cycle coinciding with play_pause while PLAYING still advances the address, then pauses.
- Reset mid-note: all state returns to reset values on the next edge. rst has priority over every input pulse.
- status = {direction_reversed, state==PLAYING}, registered.

Decomposition:
- Shared package music_pkg holds:
  - state enum {PAUSED, PLAYING}
  - direction constants FWD/REV
  - default tempo constants (BEAT_INIT/STEP/MIN/MAX defaults) for reuse by the top level and benches.
- One natural sub-module: tempo_counter. It owns beat_len, beat_cnt, saturation and the terminal pulse. Its inputs are run, tempo_up and tempo_down; its output is a one-cycle beat_tick.
- music_streamer keeps the FSM, address stepping and output registers.

Test Plan (bench parameters: ADDR_W=3, BEAT_INIT=10, BEAT_STEP=2, BEAT_MIN=4, BEAT_MAX=16; ROM = {100,200,0,400,500,600,700,800}):
- Reset, then play_pause at cycle 0 -> rom_addr 0→1 after 10 cycles; tone_period=200 two cycles after the address change; tone_enable=1.
- Play through address 2 (data 0) -> tone_enable=0 for that whole beat while status[0]=1; addr 7 -> 0 wrap observed.
- Pause at beat_cnt=5, hold 20 cycles, resume -> address advances exactly 4 cycles after resume; tone_enable=0 throughout the pause.
- reverse at address 0 -> next beat rom_addr=7, status[1]=1; reverse again on a terminal cycle -> that step still decrements.
- tempo_up ×5 -> beat length saturates at 4 cycles. tempo_down ×10 -> saturates at 16. tempo_up and tempo_down together -> length unchanged.
- Assert rst mid-beat while PLAYING reversed at address 5 -> next cycle rom_addr=0, tone_enable=0, status=00, beat length back to 10.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the music streamer: player state, step direction and
// default tempo constants used by the top level and by benches.
package music_pkg;

   typedef logic state_t;
   localparam state_t PAUSED  = 1'b0;
   localparam state_t PLAYING = 1'b1;

   typedef logic dir_t;
   localparam dir_t FWD = 1'b0;
   localparam dir_t REV = 1'b1;

   // Beat lengths in 33 MHz clock cycles.
   localparam int unsigned DEF_BEAT_INIT = 1320000;
   localparam int unsigned DEF_BEAT_STEP = 66000;
   localparam int unsigned DEF_BEAT_MIN  = 330000;
   localparam int unsigned DEF_BEAT_MAX  = 3300000;

endpackage

// File: rtl/music_streamer_tempo_counter.sv
// Beat timer: holds the adjustable beat length, counts cycles within a beat
// while running, and flags the terminal cycle of each beat.
module tempo_counter
   import music_pkg::*;
#(
   parameter int unsigned BEAT_W    = 24,
   parameter int unsigned BEAT_INIT = DEF_BEAT_INIT,
   parameter int unsigned BEAT_STEP = DEF_BEAT_STEP,
   parameter int unsigned BEAT_MIN  = DEF_BEAT_MIN,
   parameter int unsigned BEAT_MAX  = DEF_BEAT_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic tempo_up,
   input  logic tempo_down,
   output logic beat_tick
);

   localparam logic [BEAT_W-1:0] LEN_INIT = BEAT_W'(BEAT_INIT);
   localparam logic [BEAT_W-1:0] LEN_STEP = BEAT_W'(BEAT_STEP);
   localparam logic [BEAT_W-1:0] LEN_MIN  = BEAT_W'(BEAT_MIN);
   localparam logic [BEAT_W-1:0] LEN_MAX  = BEAT_W'(BEAT_MAX);

   logic [BEAT_W-1:0] beat_len_q, beat_len_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              terminal;

   // >= rather than == so a freshly shortened beat ends at once instead of wrapping.
   assign terminal  = run && (beat_cnt_q >= beat_len_q - BEAT_W'(1));
   assign beat_tick = terminal;

   always_comb begin
      beat_len_d = beat_len_q;
      if (tempo_up && !tempo_down) begin
         if (beat_len_q < LEN_MIN + LEN_STEP) beat_len_d = LEN_MIN;
         else                                 beat_len_d = beat_len_q - LEN_STEP;
      end else if (tempo_down && !tempo_up) begin
         if (beat_len_q > LEN_MAX - LEN_STEP) beat_len_d = LEN_MAX;
         else                                 beat_len_d = beat_len_q + LEN_STEP;
      end
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (terminal) beat_cnt_d = '0;
      else if (run) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_len_q <= LEN_INIT;
         beat_cnt_q <= '0;
      end else begin
         beat_len_q <= beat_len_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: rtl/music_streamer.sv
// Note sequencer feeding the piezo tone generator: steps through the note ROM
// one entry per beat and registers the period and enable for the generator.
module music_streamer
   import music_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned PERIOD_W  = 24,
   parameter int unsigned BEAT_W    = 24,
   parameter int unsigned BEAT_INIT = DEF_BEAT_INIT,
   parameter int unsigned BEAT_STEP = DEF_BEAT_STEP,
   parameter int unsigned BEAT_MIN  = DEF_BEAT_MIN,
   parameter int unsigned BEAT_MAX  = DEF_BEAT_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                play_pause,
   input  logic                reverse,
   input  logic                tempo_up,
   input  logic                tempo_down,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [PERIOD_W-1:0] rom_data,
   output logic [PERIOD_W-1:0] tone_period,
   output logic                tone_enable,
   output logic [1:0]          status
);

   state_t              state_q, state_d;
   dir_t                dir_q, dir_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [PERIOD_W-1:0] period_q;
   logic                enable_q;
   logic                beat_tick;

   tempo_counter #(
      .BEAT_W    (BEAT_W),
      .BEAT_INIT (BEAT_INIT),
      .BEAT_STEP (BEAT_STEP),
      .BEAT_MIN  (BEAT_MIN),
      .BEAT_MAX  (BEAT_MAX)
   ) u_tempo_counter (
      .clk        (clk),
      .rst        (rst),
      .run        (state_q == PLAYING),
      .tempo_up   (tempo_up),
      .tempo_down (tempo_down),
      .beat_tick  (beat_tick)
   );

   // The step taken on a terminal cycle uses the direction held before any
   // coincident reverse pulse; wrap-around falls out of the modulo arithmetic.
   always_comb begin
      state_d = state_q;
      if (play_pause) state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
      dir_d = reverse ? ((dir_q == REV) ? FWD : REV) : dir_q;
      addr_d = addr_q;
      if (beat_tick) begin
         if (dir_q == REV) addr_d = addr_q - ADDR_W'(1);
         else              addr_d = addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= PAUSED;
         dir_q    <= FWD;
         addr_q   <= '0;
         period_q <= '0;
         enable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         addr_q   <= addr_d;
         period_q <= rom_data;
         enable_q <= (state_q == PLAYING) && (rom_data != '0);
      end
   end

   assign rom_addr    = addr_q;
   assign tone_period = period_q;
   assign tone_enable = enable_q;
   assign status      = {dir_q == REV, state_q == PLAYING};

endmodule

// File: tb/tb_music_streamer.sv
// Self-checking bench for music_streamer: directed scenarios plus a randomized
// pulse run compared cycle by cycle against a behavioural player model.
module tb_music_streamer;

   localparam int ADDR_W = 3;
   localparam int SONG   = 8;
   localparam int BI     = 10;
   localparam int BS     = 2;
   localparam int BMIN   = 4;
   localparam int BMAX   = 16;

   logic        clk, rst, play_pause, reverse, tempo_up, tempo_down;
   logic [2:0]  rom_addr;
   logic [23:0] rom_data;
   logic [23:0] tone_period;
   logic        tone_enable;
   logic [1:0]  status;
   logic [23:0] rom [SONG];

   int checks = 0;
   int errors = 0;

   // Behavioural model of the player
   int m_addr, m_len, m_cnt, m_period, m_romq;
   bit m_playing, m_rev, m_enable;

   music_streamer #(
      .ADDR_W    (ADDR_W),
      .PERIOD_W  (24),
      .BEAT_W    (24),
      .BEAT_INIT (BI),
      .BEAT_STEP (BS),
      .BEAT_MIN  (BMIN),
      .BEAT_MAX  (BMAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .play_pause  (play_pause),
      .reverse     (reverse),
      .tempo_up    (tempo_up),
      .tempo_down  (tempo_down),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .tone_period (tone_period),
      .tone_enable (tone_enable),
      .status      (status)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic model_step(input bit r, pp, rv, up, dn);
      bit term;
      int romq_next;
      term      = m_playing && (m_cnt + 1 >= m_len);
      romq_next = int'(rom[m_addr]);
      if (r) begin
         m_playing = 0; m_rev = 0; m_addr = 0; m_len = BI; m_cnt = 0;
         m_period = 0; m_enable = 0;
      end else begin
         m_period = m_romq;
         m_enable = m_playing && (m_romq != 0);
         if (term) m_addr = (m_addr + (m_rev ? SONG - 1 : 1)) % SONG;
         if (m_playing) m_cnt = term ? 0 : m_cnt + 1;
         if (up && !dn) m_len = (m_len - BS < BMIN) ? BMIN : m_len - BS;
         if (dn && !up) m_len = (m_len + BS > BMAX) ? BMAX : m_len + BS;
         m_rev     = m_rev ^ rv;
         m_playing = m_playing ^ pp;
      end
      m_romq = romq_next;
   endtask

   task automatic tick(input bit r, pp, rv, up, dn);
      rst = r; play_pause = pp; reverse = rv; tempo_up = up; tempo_down = dn;
      @(posedge clk);
      model_step(r, pp, rv, up, dn);
      #1;
      rst = 0; play_pause = 0; reverse = 0; tempo_up = 0; tempo_down = 0;
   endtask

   task automatic test_reset();
      repeat (3) tick(1, 0, 0, 0, 0);
      checks++;
      if (rom_addr !== 3'd0) begin
         errors++; $display("FAIL reset_addr: got %0d, expected 0", rom_addr);
      end
      checks++;
      if (tone_period !== 24'd0) begin
         errors++; $display("FAIL reset_period: got %0d, expected 0", tone_period);
      end
      checks++;
      if (tone_enable !== 1'b0 || status !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs: enable=%b status=%b, expected 0/00", tone_enable, status);
      end
      tick(0, 0, 0, 0, 0);
      checks++;
      if (tone_period !== 24'd100 || tone_enable !== 1'b0 || rom_addr !== 3'd0) begin
         errors++;
         $display("FAIL paused_idle: period=%0d enable=%b addr=%0d, expected 100/0/0",
                  tone_period, tone_enable, rom_addr);
      end
   endtask

   task automatic test_play();
      int n;
      bit done;
      tick(0, 1, 0, 0, 0);
      checks++;
      if (status !== 2'b01) begin
         errors++; $display("FAIL play_status: got %b, expected 01", status);
      end
      n = 0; done = 0;
      while (!done && n < 50) begin
         tick(0, 0, 0, 0, 0); n++;
         if (rom_addr !== 3'd0) done = 1;
      end
      checks++;
      if (!done || n != 10 || rom_addr !== 3'd1) begin
         errors++;
         $display("FAIL first_beat: addr=%0d after %0d cycles, expected 1 after 10", rom_addr, n);
      end
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      checks++;
      if (tone_period !== 24'd200 || tone_enable !== 1'b1) begin
         errors++;
         $display("FAIL data_latency: period=%0d enable=%b, expected 200/1",
                  tone_period, tone_enable);
      end
   endtask

   task automatic test_rest_and_wrap();
      int n;
      bit seen;
      logic [2:0] prev;
      n = 0;
      while (rom_addr !== 3'd2 && n < 50) begin tick(0, 0, 0, 0, 0); n++; end
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick(0, 0, 0, 0, 0);
         checks++;
         if (tone_enable !== 1'b0 || status[0] !== 1'b1) begin
            errors++;
            $display("FAIL rest_beat[%0d]: enable=%b playing=%b, expected 0/1",
                     i, tone_enable, status[0]);
         end
      end
      seen = 0; n = 0;
      while (!seen && n < 120) begin
         prev = rom_addr;
         tick(0, 0, 0, 0, 0); n++;
         if (prev === 3'd7 && rom_addr === 3'd0) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL wrap_7_to_0: got no wrap in %0d cycles, expected one", n);
      end
   endtask

   task automatic test_pause();
      int n;
      bit done;
      logic [2:0] a0;
      n = 0;
      while (m_cnt != 5 && n < 20) begin tick(0, 0, 0, 0, 0); n++; end
      tick(0, 1, 0, 0, 0);
      a0 = rom_addr;
      tick(0, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) begin
         tick(0, 0, 0, 0, 0);
         checks++;
         if (tone_enable !== 1'b0 || rom_addr !== a0 || status[0] !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold[%0d]: enable=%b addr=%0d playing=%b, expected 0/%0d/0",
                     i, tone_enable, rom_addr, status[0], a0);
         end
      end
      tick(0, 1, 0, 0, 0);
      n = 0; done = 0;
      while (!done && n < 40) begin
         tick(0, 0, 0, 0, 0); n++;
         if (rom_addr !== a0) done = 1;
      end
      checks++;
      if (!done || n != 4) begin
         errors++; $display("FAIL resume_latency: got %0d cycles, expected 4", n);
      end
   endtask

   task automatic test_reverse();
      int n;
      bit done;
      logic [2:0] a0;
      n = 0;
      while (rom_addr !== 3'd0 && n < 120) begin tick(0, 0, 0, 0, 0); n++; end
      tick(0, 0, 1, 0, 0);
      checks++;
      if (status !== 2'b11) begin
         errors++; $display("FAIL reverse_status: got %b, expected 11", status);
      end
      n = 0; done = 0; a0 = rom_addr;
      while (!done && n < 40) begin
         tick(0, 0, 0, 0, 0); n++;
         if (rom_addr !== a0) done = 1;
      end
      checks++;
      if (rom_addr !== 3'd7) begin
         errors++; $display("FAIL reverse_wrap: got %0d, expected 7", rom_addr);
      end
      n = 0;
      while (!(m_playing && m_cnt == m_len - 1) && n < 40) begin tick(0, 0, 0, 0, 0); n++; end
      tick(0, 0, 1, 0, 0);
      checks++;
      if (rom_addr !== 3'd6 || status[1] !== 1'b0) begin
         errors++;
         $display("FAIL reverse_on_terminal: addr=%0d rev=%b, expected 6/0", rom_addr, status[1]);
      end
      n = 0; done = 0; a0 = rom_addr;
      while (!done && n < 40) begin
         tick(0, 0, 0, 0, 0); n++;
         if (rom_addr !== a0) done = 1;
      end
      checks++;
      if (rom_addr !== 3'd7) begin
         errors++; $display("FAIL forward_again: got %0d, expected 7", rom_addr);
      end
   endtask

   task automatic test_tempo();
      int n;
      int expv[3];
      bit done;
      logic [2:0] a0;
      expv[0] = BMIN; expv[1] = BMAX; expv[2] = BMAX - BS;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) repeat (5) tick(0, 0, 0, 1, 0);
         if (k == 1) repeat (10) tick(0, 0, 0, 0, 1);
         if (k == 2) begin tick(0, 0, 0, 1, 0); tick(0, 0, 0, 1, 1); end
         // Sync on one address change, then time the following full beat.
         n = 0; a0 = rom_addr;
         while (rom_addr === a0 && n < 40) begin tick(0, 0, 0, 0, 0); n++; end
         n = 0; done = 0; a0 = rom_addr;
         while (!done && n < 40) begin
            tick(0, 0, 0, 0, 0); n++;
            if (rom_addr !== a0) done = 1;
         end
         checks++;
         if (!done || n != expv[k]) begin
            errors++; $display("FAIL tempo_len[%0d]: got %0d cycles, expected %0d", k, n, expv[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit r, pp, rv, up, dn;
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 299) == 0);
         pp = ($urandom_range(0, 39) == 0);
         rv = ($urandom_range(0, 29) == 0);
         up = ($urandom_range(0, 24) == 0);
         dn = ($urandom_range(0, 24) == 0);
         tick(r, pp, rv, up, dn);
         checks++;
         if (rom_addr !== 3'(m_addr) || status !== {m_rev, m_playing}) begin
            errors++;
            $display("FAIL rand_addr_status[%0d]: addr=%0d status=%b, expected %0d/%b",
                     i, rom_addr, status, m_addr, {m_rev, m_playing});
         end
         checks++;
         if (tone_period !== 24'(m_period) || tone_enable !== m_enable) begin
            errors++;
            $display("FAIL rand_tone[%0d]: period=%0d enable=%b, expected %0d/%b",
                     i, tone_period, tone_enable, m_period, m_enable);
         end
      end
   endtask

   task automatic test_reset_mid_beat();
      int n;
      bit done;
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(0, 1, 1, 0, 0);
      n = 0;
      while (rom_addr !== 3'd5 && n < 60) begin tick(0, 0, 0, 0, 0); n++; end
      repeat (3) tick(0, 0, 0, 0, 0);
      checks++;
      if (rom_addr !== 3'd5 || status !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset: addr=%0d status=%b, expected 5/11", rom_addr, status);
      end
      tick(1, 1, 1, 1, 0);
      checks++;
      if (rom_addr !== 3'd0 || tone_enable !== 1'b0 || status !== 2'b00 || tone_period !== 24'd0)
      begin
         errors++;
         $display("FAIL mid_reset: addr=%0d enable=%b status=%b period=%0d, expected 0/0/00/0",
                  rom_addr, tone_enable, status, tone_period);
      end
      tick(0, 1, 0, 0, 0);
      n = 0; done = 0;
      while (!done && n < 40) begin
         tick(0, 0, 0, 0, 0); n++;
         if (rom_addr !== 3'd0) done = 1;
      end
      checks++;
      if (!done || n != BI || rom_addr !== 3'd1) begin
         errors++;
         $display("FAIL post_reset_beat: addr=%0d after %0d cycles, expected 1 after %0d",
                  rom_addr, n, BI);
      end
   endtask

   initial begin
      rom[0] = 24'd100; rom[1] = 24'd200; rom[2] = 24'd0;   rom[3] = 24'd400;
      rom[4] = 24'd500; rom[5] = 24'd600; rom[6] = 24'd700; rom[7] = 24'd800;
      m_addr = 0; m_len = BI; m_cnt = 0; m_period = 0; m_romq = 0;
      m_playing = 0; m_rev = 0; m_enable = 0;
      rst = 1; play_pause = 0; reverse = 0; tempo_up = 0; tempo_down = 0;
      test_reset();
      test_play();
      test_rest_and_wrap();
      test_pause();
      test_reverse();
      test_tempo();
      test_back_to_back();
      test_reset_mid_beat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
